// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - framed command packet decoder behind the UART byte receiver
// Frame: HDR0 HDR1 LEN payload[LEN] CHK, where LEN + payload + CHK sums to 0 mod 256.
module uart_frame_rx #(
    parameter int         ClkFrequency = 50000000,
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] HDR0         = 8'hAA,
    parameter logic [7:0] HDR1         = 8'h55,
    parameter int         TIMEOUT_CYC  = 50000,
    localparam int        AW           = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic          frame_ack,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          frame_pending,
    output logic          frame_valid,
    output logic [7:0]    frame_len,
    output logic          frame_err,
    output logic [1:0]    err_code,
    output logic          overrun
);

    localparam int IW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1) + ((ClkFrequency > 0) ? 0 : 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_LEN,
        S_DATA,
        S_CHK,
        S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    sum_q, sum_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          valid_d, err_d, ovr_d, pend_d;
    logic [1:0]    code_d;
    logic [7:0]    flen_d;
    logic          buf_we;
    logic          in_frame;
    logic          tmo_hit;
    logic [7:0]    chk_sum;
    logic [7:0]    buf_mem [MAX_LEN];

    assign in_frame = (state_q == S_SYNC) || (state_q == S_LEN) ||
                      (state_q == S_DATA) || (state_q == S_CHK);
    // The current silent cycle is the TIMEOUT_CYC-th one since the last byte.
    assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CYC - 1));
    assign chk_sum  = sum_q + rx_data;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        tmo_d   = '0;
        valid_d = 1'b0;
        err_d   = 1'b0;
        ovr_d   = 1'b0;
        code_d  = err_code;
        flen_d  = frame_len;
        pend_d  = frame_pending;
        buf_we  = 1'b0;

        // A byte arriving on the timeout cycle takes priority over the timeout.
        if (in_frame && !rx_valid) begin
            if (tmo_hit) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
                code_d  = 2'd3;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_data == HDR0) state_d = S_SYNC;
            end
            S_SYNC: begin
                if (rx_valid) begin
                    if (rx_data == HDR1)      state_d = S_LEN;
                    else if (rx_data == HDR0) state_d = S_SYNC;
                    else                      state_d = S_IDLE;
                end
            end
            S_LEN: begin
                if (rx_valid) begin
                    len_d = rx_data;
                    sum_d = rx_data;
                    idx_d = '0;
                    if (rx_data > 8'(MAX_LEN)) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        code_d  = 2'd2;
                    end else if (rx_data == 8'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    buf_we = 1'b1;
                    sum_d  = chk_sum;
                    idx_d  = idx_q + 1'b1;
                    if (8'(idx_q) + 8'd1 == len_q) state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (rx_valid) begin
                    if (chk_sum == 8'h00) begin
                        state_d = S_HOLD;
                        valid_d = 1'b1;
                        pend_d  = 1'b1;
                        flen_d  = len_q;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                    end
                end
            end
            S_HOLD: begin
                // An ack releases the frame and lets a same-cycle byte start the next one.
                if (frame_ack) begin
                    pend_d  = 1'b0;
                    state_d = (rx_valid && rx_data == HDR0) ? S_SYNC : S_IDLE;
                end else if (rx_valid) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            sum_q         <= '0;
            idx_q         <= '0;
            tmo_q         <= '0;
            frame_valid   <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
            err_code      <= 2'd0;
            frame_len     <= '0;
            frame_pending <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            sum_q         <= sum_d;
            idx_q         <= idx_d;
            tmo_q         <= tmo_d;
            frame_valid   <= valid_d;
            frame_err     <= err_d;
            overrun       <= ovr_d;
            err_code      <= code_d;
            frame_len     <= flen_d;
            frame_pending <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) buf_mem[idx_q[AW-1:0]] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (8'(rd_addr) >= frame_len) begin
            rd_data <= '0;
        end else begin
            rd_data <= buf_mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - self-checking bench for uart_frame_rx
// Directed frames from the test plan plus randomized frames checked against a frame-level model.
module tb_uart_frame_rx;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_ack;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_pending;
    logic       frame_valid;
    logic [7:0] frame_len;
    logic       frame_err;
    logic [1:0] err_code;
    logic       overrun;

    uart_frame_rx #(
        .ClkFrequency(50000000),
        .MAX_LEN     (MAX_LEN),
        .HDR0        (8'hAA),
        .HDR1        (8'h55),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .frame_ack    (frame_ack),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .frame_pending(frame_pending),
        .frame_valid  (frame_valid),
        .frame_len    (frame_len),
        .frame_err    (frame_err),
        .err_code     (err_code),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int code;
        int cyc;
    } ev_t;

    localparam int EV_VALID = 1;
    localparam int EV_ERR   = 2;
    localparam int EV_OVR   = 3;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         strobe_cyc = 0;
    ev_t        ev_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] exp_payload[MAX_LEN];
    int         exp_len = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            int n;
            n = int'(frame_valid) + int'(frame_err) + int'(overrun);
            if (n > 1) check("pulse_onehot", n, 1);
            if (frame_valid) ev_q.push_back('{EV_VALID, 0, cyc});
            if (frame_err)   ev_q.push_back('{EV_ERR, int'(err_code), cyc});
            if (overrun)     ev_q.push_back('{EV_OVR, 0, cyc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        strobe_cyc = cyc;
        repeat (gap) tick();
    endtask

    // gap < 0 picks a random inter-byte gap that stays inside the timeout window.
    task automatic send_q(input int gap);
        foreach (tx_q[i]) send_byte(tx_q[i], (gap < 0) ? $urandom_range(1, TMO - 2) : gap);
        tx_q.delete();
    endtask

    task automatic expect_event(input string tag, input int kind, input int code, input int at);
        check({tag, "_nevents"}, ev_q.size(), 1);
        if (ev_q.size() >= 1) begin
            check({tag, "_kind"}, ev_q[0].kind, kind);
            check({tag, "_code"}, ev_q[0].code, code);
            check({tag, "_cycle"}, ev_q[0].cyc, at);
        end
        ev_q.delete();
    endtask

    task automatic expect_none(input string tag);
        check({tag, "_nevents"}, ev_q.size(), 0);
        ev_q.delete();
    endtask

    task automatic read_chk(input string tag, input int addr, input logic [7:0] exp);
        rd_addr = 4'(addr);
        tick();
        check(tag, rd_data, exp);
    endtask

    task automatic check_held(input string tag);
        check({tag, "_pending"}, frame_pending, 1);
        check({tag, "_len"}, frame_len, exp_len);
        for (int i = 0; i < MAX_LEN; i++)
            read_chk({tag, "_rd"}, i, (i < exp_len) ? exp_payload[i] : 8'h00);
    endtask

    task automatic do_ack(input string tag);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        check({tag, "_ack_pending"}, frame_pending, 0);
        expect_none({tag, "_ack"});
    endtask

    // Frame-level model: builds a frame from length/payload and the sum-to-zero rule.
    task automatic random_frame(input int iter);
        int         kind, len;
        logic [7:0] sum, chk, b;
        logic [7:0] pl[MAX_LEN];
        kind = $urandom_range(0, 9);
        repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hAA) b = 8'h00;
            send_byte(b, $urandom_range(1, 5));
        end
        expect_none("rnd_junk");
        if (kind == 0) begin
            len = $urandom_range(MAX_LEN + 1, 255);
            tx_q = '{8'hAA, 8'h55, 8'(len)};
            send_q(-1);
            expect_event("rnd_long", EV_ERR, 2, strobe_cyc);
        end else begin
            len = $urandom_range(0, MAX_LEN);
            sum = 8'(len);
            tx_q = '{8'hAA, 8'h55, 8'(len)};
            for (int i = 0; i < len; i++) begin
                pl[i] = 8'($urandom_range(0, 255));
                sum   = sum + pl[i];
                tx_q.push_back(pl[i]);
            end
            chk = 8'h00 - sum;
            if (kind <= 2) chk = chk ^ 8'($urandom_range(1, 255));
            tx_q.push_back(chk);
            send_q(-1);
            if (kind <= 2) begin
                expect_event("rnd_badchk", EV_ERR, 1, strobe_cyc);
                check("rnd_badchk_pending", frame_pending, 0);
                check("rnd_keep_len", frame_len, exp_len);
            end else begin
                expect_event("rnd_good", EV_VALID, 0, strobe_cyc);
                exp_len = len;
                for (int i = 0; i < len; i++) exp_payload[i] = pl[i];
                check_held("rnd_good");
                do_ack("rnd_good");
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        frame_ack = 1'b0;
        rd_addr   = 4'd0;
        repeat (3) tick();
        check("rst_rd_data", rd_data, 0);
        check("rst_pending", frame_pending, 0);
        check("rst_valid", frame_valid, 0);
        check("rst_len", frame_len, 0);
        check("rst_err", frame_err, 0);
        check("rst_code", err_code, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        tick();

        // Good frame with 10-cycle gaps
        tx_q = '{8'hAA, 8'h55, 8'h02, 8'h01, 8'h02, 8'hFB};
        send_q(10);
        expect_event("good", EV_VALID, 0, strobe_cyc);
        check("good_pending", frame_pending, 1);
        check("good_len", frame_len, 2);
        read_chk("good_rd0", 0, 8'h01);
        read_chk("good_rd1", 1, 8'h02);
        read_chk("good_rd2", 2, 8'h00);
        do_ack("good");
        exp_len = 2;
        exp_payload[0] = 8'h01;
        exp_payload[1] = 8'h02;

        // Checksum error, then a good frame
        tx_q = '{8'hAA, 8'h55, 8'h02, 8'h01, 8'h02, 8'hFA};
        send_q(3);
        expect_event("badchk", EV_ERR, 1, strobe_cyc);
        check("badchk_pending", frame_pending, 0);
        tx_q = '{8'hAA, 8'h55, 8'h02, 8'h01, 8'h02, 8'hFB};
        send_q(3);
        expect_event("after_bad", EV_VALID, 0, strobe_cyc);
        do_ack("after_bad");

        // Repeated HDR0 and empty payload
        tx_q = '{8'hAA, 8'hAA, 8'h55, 8'h00, 8'h00};
        send_q(2);
        expect_event("len0", EV_VALID, 0, strobe_cyc);
        check("len0_len", frame_len, 0);
        read_chk("len0_rd0", 0, 8'h00);
        do_ack("len0");
        exp_len = 0;

        // Oversize length, following byte ignored, broken sync silent
        tx_q = '{8'hAA, 8'h55, 8'h11};
        send_q(2);
        expect_event("oversize", EV_ERR, 2, strobe_cyc);
        send_byte(8'h01, 3);
        send_byte(8'hAA, 3);
        send_byte(8'h12, 3);
        expect_none("badsync");

        // Bytes exactly at the timeout boundary keep the frame alive
        tx_q = '{8'hAA, 8'h55, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF7};
        send_q(TMO - 1);
        expect_event("tmo_edge", EV_VALID, 0, strobe_cyc);
        exp_len = 3;
        exp_payload[0] = 8'h01;
        exp_payload[1] = 8'h02;
        exp_payload[2] = 8'h03;
        check_held("tmo_edge");
        do_ack("tmo_edge");

        // Silence inside a frame times out after exactly TMO idle cycles
        tx_q = '{8'hAA, 8'h55, 8'h03, 8'h01};
        send_q(2);
        repeat (TMO + 5) tick();
        expect_event("timeout", EV_ERR, 3, strobe_cyc + TMO);
        check("timeout_keep_len", frame_len, 3);

        // Overrun while held, then ack racing with a new HDR0
        tx_q = '{8'hAA, 8'h55, 8'h02, 8'h01, 8'h02, 8'hFB};
        send_q(2);
        expect_event("ovr_setup", EV_VALID, 0, strobe_cyc);
        exp_len = 2;
        exp_payload[0] = 8'h01;
        exp_payload[1] = 8'h02;
        send_byte(8'h33, 2);
        expect_event("overrun", EV_OVR, 0, strobe_cyc);
        check_held("ovr_held");
        rx_data   = 8'hAA;
        rx_valid  = 1'b1;
        frame_ack = 1'b1;
        tick();
        rx_valid  = 1'b0;
        frame_ack = 1'b0;
        tick();
        expect_none("ack_race");
        check("ack_race_pending", frame_pending, 0);
        tx_q = '{8'h55, 8'h01, 8'h07, 8'hF8};
        send_q(2);
        expect_event("race_frame", EV_VALID, 0, strobe_cyc);
        exp_len = 1;
        exp_payload[0] = 8'h07;
        check_held("race_frame");
        do_ack("race_frame");

        // Reset mid-frame aborts silently
        tx_q = '{8'hAA, 8'h55, 8'h04, 8'h01};
        send_q(2);
        rst = 1'b1;
        tick();
        check("midrst_pending", frame_pending, 0);
        check("midrst_len", frame_len, 0);
        check("midrst_rd_data", rd_data, 0);
        check("midrst_pulses", {frame_valid, frame_err, overrun, err_code}, 0);
        rst = 1'b0;
        exp_len = 0;
        repeat (TMO + 5) tick();
        expect_none("midrst");
        tx_q = '{8'hAA, 8'h55, 8'h02, 8'h01, 8'h02, 8'hFB};
        send_q(2);
        expect_event("post_rst", EV_VALID, 0, strobe_cyc);
        exp_len = 2;
        exp_payload[0] = 8'h01;
        exp_payload[1] = 8'h02;
        check_held("post_rst");
        do_ack("post_rst");

        for (int it = 0; it < 25; it++) random_frame(it);

        repeat (3) tick();
        expect_none("final");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
Frame decoder that sits directly behind the UART byte receiver and consumes its one-cycle data-ready strobes. It recovers framed command packets in this format: 0xAA, 0x55, LEN, LEN payload bytes, CHK. It validates each frame, stores the payload in an internal buffer, and holds the frame for the flight-control logic until that logic acknowledges it. Malformed, stalled or overrun frames are reported by error pulses.

Parameters:
ClkFrequency, 50000000, clock frequency in Hz (documentation only; timeout is expressed in cycles)
MAX_LEN, 16, maximum payload bytes; power of 2, range 2..128
HDR0, 8'hAA, first sync byte
HDR1, 8'h55, second sync byte
TIMEOUT_CYC, 50000, maximum clock cycles between consecutive bytes inside a frame

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_data  in  8  received byte; valid only while rx_valid is high
rx_valid  in  1  one-cycle strobe per received byte
frame_ack  in  1  consumer releases the held frame
rd_addr  in  log2(MAX_LEN)  payload buffer read address
rd_data  out  8  payload byte at rd_addr, registered
frame_pending  out  1  level; a valid frame is held in the buffer
frame_valid  out  1  one-cycle pulse when a good frame completes
frame_len  out  8  payload length of the held frame
frame_err  out  1  one-cycle pulse on a discarded frame
err_code  out  2  cause, valid with frame_err: 1=checksum, 2=length>MAX_LEN, 3=timeout
overrun  out  1  one-cycle pulse when a byte is dropped because a frame is pending

Behaviour:
- Single clock domain, synchronous active-high reset. The reset value of every output is 0. Reset mid-frame aborts the frame silently: no error pulse, state goes to IDLE, buffer contents are don't-care.
- State machine: IDLE, SYNC, LEN, DATA, CHK, HOLD. States only advance on cycles where rx_valid is high, except for timeout and ack transitions.
  - IDLE: byte == HDR0 -> SYNC; any other byte is ignored.
  - SYNC: byte == HDR1 -> LEN; byte == HDR0 -> stay in SYNC; any other byte -> IDLE, with no error pulse.
  - LEN: latch LEN and initialise sum = LEN.
    - LEN > MAX_LEN -> frame_err with err_code=2, then IDLE.
    - LEN == 0 -> CHK.
    - Otherwise -> DATA with write index 0.
  - DATA: write the byte to buf[index], add it to the sum mod 256, increment index. After the LEN-th byte -> CHK.
  - CHK: if (sum + byte) mod 256 == 0, the frame is good: frame_valid pulses, frame_pending is set, frame_len = LEN, state -> HOLD. If not, frame_err pulses with err_code=1 and state -> IDLE.
  - HOLD: frame_ack -> IDLE; frame_pending clears on the next cycle.
- Latency: frame_valid, frame_err and overrun are registered and assert exactly one cycle after the qualifying rx_valid cycle or timeout cycle.
- Timeout counter:
  - Cleared on every rx_valid, and held at 0 in IDLE and HOLD.
  - In SYNC, LEN, DATA and CHK it increments each cycle.
  - When it reaches TIMEOUT_CYC with no byte: frame_err with err_code=3, state -> IDLE.
  - If a byte arrives on the same cycle the count hits TIMEOUT_CYC, the byte wins and no timeout occurs.
- HOLD with rx_valid and no frame_ack: the byte is dropped, overrun pulses, and the buffer and frame_len are unchanged.
- HOLD with rx_valid and frame_ack in the same cycle: the ack takes effect, the byte is evaluated as if in IDLE (HDR0 -> SYNC), and there is no overrun.
- frame_ack outside HOLD is ignored.
- frame_len holds its value until the next good frame; it is not cleared by ack.
- Buffer writes happen only in DATA, so the held payload is never modified while frame_pending is high.
- Read port:
  - rd_data is registered from rd_addr with 1-cycle latency, in any state.
  - If rd_addr >= frame_len, rd_data = 0x00.
- Width rules: the sum is 8-bit and wraps. The write index is log2(MAX_LEN)+1 bits. The timeout counter is sized to hold TIMEOUT_CYC.
- Only one of frame_valid, frame_err and overrun can pulse in any cycle.

Test Plan:
- Good frame: bytes AA 55 02 01 02 FB, gaps of 10 cycles. Required: frame_valid pulse 1 cycle after the FB strobe, frame_pending=1, frame_len=2. rd_addr=0 gives 0x01 and rd_addr=1 gives 0x02, each a cycle later; rd_addr=2 gives 0x00. frame_ack clears frame_pending on the next cycle.
- Checksum error: AA 55 02 01 02 FA. Required: frame_err with err_code=1, no frame_valid, frame_pending stays 0. A following good frame is accepted.
- Sync and length handling:
  - AA AA 55 00 00 is accepted, with frame_len=0.
  - AA 55 11 (MAX_LEN=16) gives err_code=2, and the next byte 0x01 is ignored as being in IDLE.
  - AA 12 returns to IDLE with no error.
- Timeout: AA 55 03 01, then silence. Required: frame_err with err_code=3 after exactly TIMEOUT_CYC idle cycles (use TIMEOUT_CYC=20). A byte arriving on cycle 20 prevents the timeout.
- Overrun and ack race: with a frame held, send 0x33 without ack. Required: overrun pulse, payload and frame_len unchanged. Then send AA together with frame_ack: no overrun, state moves to SYNC, and 55 01 07 F8 completes a frame with frame_len=1 and buf[0]=0x07.
- Reset mid-frame: assert rst after AA 55 04 01. Required: all outputs 0 and no error pulse. A subsequent good frame decodes normally.
